// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stall/flush controller and the
// pipeline registers it steers.
package pipeline_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      WAIT_IF = 1'b1
   } ctrl_state_t;

   // Stage index doubles as the index of the pipeline register that follows it.
   localparam int STG_PC  = 0;
   localparam int STG_IF  = 1;
   localparam int STG_ID  = 2;
   localparam int STG_EX  = 3;
   localparam int STG_MEM = 4;
   localparam int NUM_STG = 5;

   // Instruction word loaded into IF/ID when it takes a bubble (addi x0,x0,0).
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Highest-priority stalling stage, or STG_PC when nothing stalls.
   function automatic logic [2:0] stall_level(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
      logic [2:0] lvl;
      lvl = 3'(STG_PC);
      if (req_if)  lvl = 3'(STG_IF);
      if (req_id)  lvl = 3'(STG_ID);
      if (req_ex)  lvl = 3'(STG_EX);
      if (req_mem) lvl = 3'(STG_MEM);
      return lvl;
   endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: per-register enables and
// bubbles, exception redirect sequencing and a saturating stall counter.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_if,
   input  logic              stallreq_id,
   input  logic              stallreq_ex,
   input  logic              stallreq_mem,
   input  logic              excp_valid,
   input  logic [ADDR_W-1:0] excp_target,
   output logic              pc_en,
   output logic              pc_load,
   output logic [ADDR_W-1:0] new_pc,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              ex_mem_en,
   output logic              mem_wb_en,
   output logic              if_id_bubble,
   output logic              id_ex_bubble,
   output logic              ex_mem_bubble,
   output logic              mem_wb_bubble,
   output logic              flush,
   output logic              busy_redirect,
   output logic [CNT_W-1:0]  stall_cycles
);

   ctrl_state_t       r_state;
   ctrl_state_t       w_state_next;
   logic [ADDR_W-1:0] r_pending_pc;
   logic [ADDR_W-1:0] w_pending_pc_next;
   logic [CNT_W-1:0]  r_stall_cycles;
   logic              w_cnt_inc;
   logic              w_exc;
   logic              w_any_req;
   logic [2:0]        w_lvl;
   logic [NUM_STG-1:1] w_reg_en;
   logic [NUM_STG-1:1] w_reg_bub;

   assign w_exc     = excp_valid & ~stallreq_mem;
   assign w_any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
   assign w_lvl     = stall_level(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);

   // Registers upstream of the stalling stage hold, the one right after it
   // takes the bubble, everything downstream keeps draining.
   genvar gi;
   generate
      for (gi = 1; gi < NUM_STG; gi++) begin : g_reg
         assign w_reg_en[gi]  = (w_lvl == 3'(STG_PC)) || (3'(gi) > w_lvl);
         assign w_reg_bub[gi] = (w_lvl == 3'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= RUN;
         r_pending_pc   <= '0;
         r_stall_cycles <= '0;
      end else begin
         r_state      <= w_state_next;
         r_pending_pc <= w_pending_pc_next;
         if (w_cnt_inc && !(&r_stall_cycles))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_pending_pc_next = r_pending_pc;
      w_cnt_inc         = 1'b0;
      pc_en             = 1'b0;
      pc_load           = 1'b0;
      new_pc            = excp_target;
      if_id_en          = 1'b0;
      id_ex_en          = 1'b0;
      ex_mem_en         = 1'b0;
      mem_wb_en         = 1'b0;
      if_id_bubble      = 1'b0;
      id_ex_bubble      = 1'b0;
      ex_mem_bubble     = 1'b0;
      mem_wb_bubble     = 1'b0;
      flush             = 1'b0;
      busy_redirect     = 1'b0;

      if (!rst) begin
         flush  = 1'b1;
         new_pc = '0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_exc) begin
                  flush = 1'b1;
                  if (!stallreq_if) begin
                     pc_en   = 1'b1;
                     pc_load = 1'b1;
                  end else begin
                     w_state_next      = WAIT_IF;
                     w_pending_pc_next = excp_target;
                  end
               end else begin
                  pc_en         = (w_lvl == 3'(STG_PC));
                  if_id_en      = w_reg_en[STG_IF];
                  id_ex_en      = w_reg_en[STG_ID];
                  ex_mem_en     = w_reg_en[STG_EX];
                  mem_wb_en     = w_reg_en[STG_MEM];
                  if_id_bubble  = w_reg_bub[STG_IF];
                  id_ex_bubble  = w_reg_bub[STG_ID];
                  ex_mem_bubble = w_reg_bub[STG_EX];
                  mem_wb_bubble = w_reg_bub[STG_MEM];
                  w_cnt_inc     = w_any_req;
               end
            end
            WAIT_IF: begin
               // Pipeline is empty here; only the fetch miss matters.
               flush         = 1'b1;
               busy_redirect = 1'b1;
               new_pc        = r_pending_pc;
               if (!stallreq_if) begin
                  pc_en        = 1'b1;
                  pc_load      = 1'b1;
                  w_state_next = RUN;
               end
            end
            default: w_state_next = RUN;
         endcase
      end
   end

   assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Per register it drives an enable and a bubble (load-NOP) signal from the stage stall requests.
- It also sequences exception redirects, holding the PC redirect while an instruction-fetch miss is still outstanding.
- It keeps a stall-cycle performance counter.

Parameters:
ADDR_W, 32, PC/target address width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
stallreq_if  in  1  instruction fetch not ready (icache miss outstanding)
stallreq_id  in  1  load-use hazard in ID
stallreq_ex  in  1  multi-cycle EX op busy (mul/div)
stallreq_mem  in  1  data access not complete
excp_valid  in  1  MEM-stage exception/eret, valid when stallreq_mem=0
excp_target  in  ADDR_W  redirect address for excp_valid
pc_en  out  1  PC register update enable
pc_load  out  1  load new_pc into PC this cycle
new_pc  out  ADDR_W  redirect address
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables
if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble  out  1 each  register loads NOP/zero this cycle (overrides en)
flush  out  1  clear all pipeline registers
busy_redirect  out  1  high in WAIT_IF
stall_cycles  out  CNT_W  saturating count of stalled RUN cycles

Behaviour:
- Outputs are combinational from inputs and state. State, pending_pc and stall_cycles are flops.
- Reset (rst=0, async):
  - State and registers: state=RUN, pending_pc=0, stall_cycles=0.
  - Outputs while rst=0: all *_en=0, all bubbles=0, flush=1, pc_load=0, new_pc=0, busy_redirect=0.
- Exception accepted: exc = excp_valid & ~stallreq_mem. excp_valid is ignored while stallreq_mem=1.
- RUN, exc=0: the highest requesting stage wins (mem > ex > id > if).
  - mem: pc_en, if_id_en, id_ex_en, ex_mem_en=0; mem_wb_bubble=1.
  - ex: pc_en, if_id_en, id_ex_en=0; ex_mem_bubble=1; mem_wb_en=1.
  - id: pc_en, if_id_en=0; id_ex_bubble=1; downstream en=1.
  - if: pc_en=0; if_id_bubble=1; downstream en=1.
  - no request: all en=1, bubbles=0.
  - Bubbles appear only on the single register directly after the stalling stage.
- RUN, exc=1:
  - Same cycle: flush=1; pipeline register enables are don't-care (flush dominates).
  - stallreq_if=0: pc_load=1, pc_en=1, new_pc=excp_target; stay RUN.
  - stallreq_if=1: pc_en=0, pc_load=0; pending_pc<=excp_target; next state WAIT_IF.
- WAIT_IF:
  - Each cycle: flush=1, busy_redirect=1, new_pc=pending_pc.
  - excp_valid and stallreq_id/ex/mem are ignored (pipeline is empty).
  - stallreq_if=1: pc_en=0, pc_load=0; stay.
  - stallreq_if=0: pc_load=1, pc_en=1; the stale fetched instruction is discarded by flush; next state RUN.
  - Redirect latency from exception to pc_load is N+1 cycles, where N is the number of remaining stallreq_if-high cycles.
- stall_cycles:
  - Increments in RUN cycles with exc=0 and any stallreq_* high.
  - Saturates at all-ones; never wraps.
  - Not incremented in WAIT_IF or in flush cycles.
- new_pc in RUN when no exception is accepted: excp_target (don't-care, pc_load=0).

Decomposition:
- Shared package pipeline_pkg:
  - ctrl_state_t enum {RUN, WAIT_IF}
  - stage index constants (STG_PC, STG_IF, STG_ID, STG_EX, STG_MEM)
  - NOP instruction constant used by bubble consumers
- No sub-module. The saturating counter is small enough to stay inline.

Test Plan:
1. Reset: assert rst=0 mid-WAIT_IF with pending_pc=0x80000180 -> state=RUN, pending_pc=0, stall_cycles=0, flush=1, all *_en=0, pc_load=0; release rst -> all en=1 when no requests.
2. Priority: stallreq_id=1 and stallreq_ex=1 for 3 cycles -> pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1, mem_wb_en=1, id_ex_bubble=0; stall_cycles goes 0->3.
3. Mem-gated exception: excp_valid=1 with stallreq_mem=1 for 2 cycles, then stallreq_mem=0 -> flush only in the 3rd cycle, with pc_load=1, new_pc=excp_target=0xBFC00380.
4. Redirect during fetch miss: exc with excp_target=0x80000180 while stallreq_if=1 for 4 more cycles -> busy_redirect=1 and flush=1 for 4 cycles, then 1 cycle with pc_load=1, new_pc=0x80000180; then RUN.
5. WAIT_IF ignores inputs: second excp_valid (target 0x0) plus stallreq_ex=1 during WAIT_IF -> new_pc stays 0x80000180, stall_cycles unchanged.
6. Saturation: CNT_W=4, stallreq_if held 20 cycles -> stall_cycles reaches 15 and stays 15; if_id_bubble=1 throughout.
